sprite_draw_scheduler: RTL and testbench
========================================

# sprite_draw_scheduler

Round-robin scheduler that shares the single VGA plot port between up to NUM_REQ sprite requesters (player character, obstacles, erase passes). It grants one requester at a time, steps the shared pixel-offset table through indices 1..PIXELS, adds each offset to the winner's base coordinates, and drives one registered plot strobe per pixel. It sits between the game-logic FSMs and the VGA adapter, replacing per-sprite free-running counters.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- PIXELS, 23, offset-table entries per sprite; valid indices 1..PIXELS
- IDX_W, 5, width of pix_idx; must satisfy 2^IDX_W > PIXELS
- X_MAX, 159, last visible column
- Y_MAX, 119, last visible row

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req  in  NUM_REQ  level request per requester
- req_x  in  8*NUM_REQ  base x per requester, slice i = [8i+7:8i]
- req_y  in  7*NUM_REQ  base y per requester, slice i = [7i+6:7i]
- req_color  in  3*NUM_REQ  colour per requester
- off_x  in  4  x offset from combinational table, indexed by pix_idx
- off_y  in  5  y offset from combinational table, indexed by pix_idx
- pix_idx  out  IDX_W  current table index
- grant  out  NUM_REQ  one-hot owner of the plot port
- done  out  NUM_REQ  one-cycle pulse to owner when its sprite is complete
- out_x  out  8  plot x
- out_y  out  7  plot y
- out_color  out  3  plot colour
- plot  out  1  write strobe to VGA adapter
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, LOAD, DRAW, DONE. Reset value: IDLE; all outputs 0; rr pointer 0.
- IDLE: if req != 0, pick first set bit searching upward from rr pointer (wrapping); latch winner index w, req_x/req_y/req_color slices; go to LOAD. Otherwise stay.
- LOAD: grant[w]=1, pix_idx=0, plot=0; go to DRAW with pix_idx=1.
- DRAW: on each edge, register out_x/out_y/out_color from current pix_idx; pix_idx increments; when pix_idx==PIXELS on the edge, go to DONE.
- DONE: final pixel's plot is visible; done[w]=1; grant[w]=1. Next edge: IDLE, grant=0, plot=0, pix_idx=0, rr pointer = (w+1) mod NUM_REQ.
- Arithmetic: sx = {1'b0,base_x} + off_x (9 bit), sy = {1'b0,base_y} + off_y (8 bit). plot registered high only if sx<=X_MAX and sy<=Y_MAX; clipped pixels still consume a cycle and out_x/out_y hold the truncated sums.
- Inputs req_x/req_y/req_color are sampled only on the IDLE->LOAD edge; later changes are ignored.
- req deasserted mid-sprite: ignored, sprite completes and done still pulses.
- req held after done: requester competes again in IDLE; rr pointer guarantees every other pending requester is served first.
- reset asserted in any state: immediately IDLE, all outputs 0, no done pulse.

## Timing
- IDLE->LOAD: 1 cycle after req seen. Grant visible in LOAD.
- Sprite occupancy: LOAD (1) + DRAW (PIXELS) + DONE (1) = PIXELS+2 cycles; 25 at default.
- Plot latency: one cycle from pix_idx to plot/out_x/out_y. First plot in 2nd DRAW cycle; last in DONE.
- Back-to-back: one IDLE cycle between sprites; min period PIXELS+3 cycles.
- grant and busy change only on clock edges (except reset); done high exactly one cycle per sprite.

## Test plan
- Single req[0], base (10,20), table off = (k mod 16, k): 23 plot pulses at (10+k mod 16, 20+k) for k=1..23, done[0] 25 cycles after LOAD entry, busy low after.
- req=4'b1010 simultaneous from reset: grant[1] first, then grant[3]; done[1] precedes grant[3] by 2 cycles; rr pointer ends at 0.
- Clipping: base (155,115), off_x=8, off_y=10 for all k: zero plot pulses, done still at cycle 25.
- Reset at 10th DRAW cycle: plot, grant, busy, pix_idx drop to 0 asynchronously; no done; next req restarts at pix_idx 1.
- All four req held continuously: grants cycle 0,1,2,3,0; each sprite period 26 cycles.
- req_x changed during DRAW: plotted x uses value latched at IDLE->LOAD edge.

Source files
------------

// File: rtl/sprite_draw_scheduler.sv
// sprite_draw_scheduler
// Round-robin owner of the single VGA plot port. The winning requester's base
// coordinates are latched once, then the shared offset table is walked through
// indices 1..PIXELS. Each offset is added to the base, and one registered plot
// strobe is produced per on-screen pixel.
module sprite_draw_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int PIXELS  = 23,
   parameter int IDX_W   = 5,
   parameter int X_MAX   = 159,
   parameter int Y_MAX   = 119
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [8*NUM_REQ-1:0]   req_x,
   input  logic [7*NUM_REQ-1:0]   req_y,
   input  logic [3*NUM_REQ-1:0]   req_color,
   input  logic [3:0]             off_x,
   input  logic [4:0]             off_y,
   output logic [IDX_W-1:0]       pix_idx,
   output logic [NUM_REQ-1:0]     grant,
   output logic [NUM_REQ-1:0]     done,
   output logic [7:0]             out_x,
   output logic [6:0]             out_y,
   output logic [2:0]             out_color,
   output logic                   plot,
   output logic                   busy
);

   localparam int RR_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_DONE} state_t;

   state_t              r_state;
   logic [RR_W-1:0]     r_rr;
   logic [RR_W-1:0]     r_w;
   logic [7:0]          r_bx;
   logic [6:0]          r_by;
   logic [2:0]          r_col;
   logic [IDX_W-1:0]    r_pix_idx;
   logic [NUM_REQ-1:0]  r_grant;
   logic [NUM_REQ-1:0]  r_done;
   logic [7:0]          r_out_x;
   logic [6:0]          r_out_y;
   logic [2:0]          r_out_color;
   logic                r_plot;
   logic                r_busy;

   logic [RR_W-1:0]     w_win;
   logic [NUM_REQ-1:0]  w_win_onehot;
   logic [8:0]          w_sx;
   logic [7:0]          w_sy;

   // First pending requester at or above the pointer, wrapping past the top.
   function automatic logic [RR_W-1:0] f_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [RR_W-1:0]    p);
      logic [RR_W-1:0] win;
      logic            found;
      int              j;
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = int'(p) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found && r[RR_W'(j)]) begin
            found = 1'b1;
            win   = RR_W'(j);
         end
      end
      return win;
   endfunction

   // Pointer moves one past the requester just served so it goes to the back.
   function automatic logic [RR_W-1:0] f_next_rr(input logic [RR_W-1:0] w);
      if (int'(w) == NUM_REQ - 1) return '0;
      return w + RR_W'(1);
   endfunction

   // Full-width sums are compared so that carries past the screen edge clip.
   function automatic logic f_on_screen(input logic [8:0] sx, input logic [7:0] sy);
      return (sx <= 9'(X_MAX)) && (sy <= 8'(Y_MAX));
   endfunction

   assign w_win        = f_pick(req, r_rr);
   assign w_win_onehot = NUM_REQ'(1) << w_win;
   assign w_sx         = {1'b0, r_bx} + {5'b0, off_x};
   assign w_sy         = {1'b0, r_by} + {3'b0, off_y};

   // Scheduler FSM: arbitration, table walk and all registered plot outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_rr        <= '0;
         r_w         <= '0;
         r_bx        <= '0;
         r_by        <= '0;
         r_col       <= '0;
         r_pix_idx   <= '0;
         r_grant     <= '0;
         r_done      <= '0;
         r_out_x     <= '0;
         r_out_y     <= '0;
         r_out_color <= '0;
         r_plot      <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_grant   <= '0;
               r_done    <= '0;
               r_plot    <= 1'b0;
               r_pix_idx <= '0;
               if (|req) begin
                  r_w     <= w_win;
                  r_bx    <= req_x[8*w_win +: 8];
                  r_by    <= req_y[7*w_win +: 7];
                  r_col   <= req_color[3*w_win +: 3];
                  r_grant <= w_win_onehot;
                  r_busy  <= 1'b1;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_pix_idx <= IDX_W'(1);
               r_state   <= S_DRAW;
            end
            S_DRAW: begin
               r_out_x     <= w_sx[7:0];
               r_out_y     <= w_sy[6:0];
               r_out_color <= r_col;
               r_plot      <= f_on_screen(w_sx, w_sy);
               if (r_pix_idx == IDX_W'(PIXELS)) begin
                  r_pix_idx <= '0;
                  r_done    <= r_grant;
                  r_state   <= S_DONE;
               end else begin
                  r_pix_idx <= r_pix_idx + IDX_W'(1);
               end
            end
            S_DONE: begin
               r_grant   <= '0;
               r_done    <= '0;
               r_plot    <= 1'b0;
               r_busy    <= 1'b0;
               r_pix_idx <= '0;
               r_rr      <= f_next_rr(r_w);
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign pix_idx   = r_pix_idx;
   assign grant     = r_grant;
   assign done      = r_done;
   assign out_x     = r_out_x;
   assign out_y     = r_out_y;
   assign out_color = r_out_color;
   assign plot      = r_plot;
   assign busy      = r_busy;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Bench for sprite_draw_scheduler: directed sprites, scoreboard of expected
// plotted pixels built from the base coordinates and the offset table.
module tb_sprite_draw_scheduler;

   localparam int NUM_REQ = 4;
   localparam int PIXELS  = 23;
   localparam int IDX_W   = 5;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [NUM_REQ-1:0]     req;
   logic [8*NUM_REQ-1:0]   req_x;
   logic [7*NUM_REQ-1:0]   req_y;
   logic [3*NUM_REQ-1:0]   req_color;
   logic [3:0]             off_x;
   logic [4:0]             off_y;
   logic [IDX_W-1:0]       pix_idx;
   logic [NUM_REQ-1:0]     grant;
   logic [NUM_REQ-1:0]     done;
   logic [7:0]             out_x;
   logic [6:0]             out_y;
   logic [2:0]             out_color;
   logic                   plot;
   logic                   busy;

   logic                   tbl_mode;
   int                     bx [NUM_REQ];
   int                     by [NUM_REQ];
   logic [2:0]             bc [NUM_REQ];
   logic [17:0]            sb [$];
   int                     nchk  = 0;
   int                     npass = 0;
   int                     nplot = 0;
   int                     cyc   = 0;
   int                     lc    [5];
   int                     tmp;

   sprite_draw_scheduler #(
      .NUM_REQ(NUM_REQ), .PIXELS(PIXELS), .IDX_W(IDX_W), .X_MAX(159), .Y_MAX(119)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
      .req_color(req_color), .off_x(off_x), .off_y(off_y), .pix_idx(pix_idx),
      .grant(grant), .done(done), .out_x(out_x), .out_y(out_y),
      .out_color(out_color), .plot(plot), .busy(busy)
   );

   always #5 clk = ~clk;

   // Offset table: mode 0 is (k mod 16, k); mode 1 is a constant (8, 10).
   always_comb begin
      off_x = 4'd0;
      off_y = 5'd0;
      if (tbl_mode == 1'b0) begin
         off_x = pix_idx[3:0];
         off_y = pix_idx;
      end else begin
         off_x = 4'd8;
         off_y = 5'd10;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance one clock; sample 1 time unit after the edge, score any plot.
   task automatic step();
      logic [17:0] e;
      @(posedge clk);
      #1;
      cyc++;
      if (plot === 1'b1) begin
         nplot++;
         if (sb.size() == 0) chk("plot_unexpected", {31'd0, plot}, 32'd0);
         else begin
            e = sb.pop_front();
            chk("pixel", {14'd0, out_x, out_y, out_color}, {14'd0, e});
         end
      end
   endtask

   task automatic set_base(input int i, input int x, input int y, input logic [2:0] c);
      bx[i] = x;
      by[i] = y;
      bc[i] = c;
      req_x[8*i +: 8]     = 8'(x);
      req_y[7*i +: 7]     = 7'(y);
      req_color[3*i +: 3] = c;
   endtask

   task automatic push_sprite(input int w, input logic m, output int cnt);
      int sx, sy;
      cnt = 0;
      for (int k = 1; k <= PIXELS; k++) begin
         sx = bx[w] + ((m == 1'b0) ? (k % 16) : 8);
         sy = by[w] + ((m == 1'b0) ? k : 10);
         if (sx <= 159 && sy <= 119) begin
            sb.push_back({8'(sx), 7'(sy), bc[w]});
            cnt++;
         end
      end
   endtask

   task automatic reset_pulse();
      step();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   // One complete sprite for requester w, from the wait for grant through the
   // IDLE cycle after done.
   task automatic run_sprite(input int w, input logic m, input logic [NUM_REQ-1:0] req_after,
                             input bit scramble, output int load_cyc);
      int exp_plots, waited, n;
      tbl_mode = m;
      push_sprite(w, m, exp_plots);
      nplot  = 0;
      waited = 0;
      while (grant == '0 && waited < 6) begin
         step();
         waited++;
      end
      chk("load_wait", waited, 1);
      chk("grant_load", {28'd0, grant}, 32'd1 << w);
      chk("busy_load", {31'd0, busy}, 32'd1);
      chk("pix_load", {27'd0, pix_idx}, 32'd0);
      load_cyc = cyc;
      req = req_after;
      if (scramble) begin
         req_x     = ~req_x;
         req_y     = ~req_y;
         req_color = ~req_color;
      end
      step();
      chk("pix_draw1", {27'd0, pix_idx}, 32'd1);
      n = 1;
      while (done == '0 && n < 40) begin
         step();
         n++;
      end
      chk("done_cycle", n, PIXELS + 1);
      chk("done_vec", {28'd0, done}, 32'd1 << w);
      chk("grant_done", {28'd0, grant}, 32'd1 << w);
      chk("plot_count", nplot, exp_plots);
      step();
      chk("done_pulse", {28'd0, done}, 32'd0);
      chk("grant_idle", {28'd0, grant}, 32'd0);
      chk("busy_idle", {31'd0, busy}, 32'd0);
      chk("plot_idle", {31'd0, plot}, 32'd0);
      chk("sb_empty", sb.size(), 0);
   endtask

   initial begin
      reset     = 1'b1;
      req       = '0;
      req_x     = '0;
      req_y     = '0;
      req_color = '0;
      tbl_mode  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) set_base(i, 0, 0, 3'd0);
      step();
      step();
      chk("rst_grant", {28'd0, grant}, 32'd0);
      chk("rst_done", {28'd0, done}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_plot", {31'd0, plot}, 32'd0);
      chk("rst_pix", {27'd0, pix_idx}, 32'd0);
      chk("rst_xyc", {14'd0, out_x, out_y, out_color}, 32'd0);
      reset = 1'b0;
      step();

      // Single requester, mode-0 table, req dropped once granted.
      set_base(0, 10, 20, 3'd5);
      req = 4'b0001;
      run_sprite(0, 1'b0, 4'b0000, 1'b0, tmp);
      step();
      chk("stay_idle", {31'd0, busy}, 32'd0);

      // Simultaneous 1 and 3 from reset; requester 3 partly clips in y.
      reset_pulse();
      set_base(1, 100, 90, 3'd2);
      set_base(3, 140, 100, 3'd7);
      req = 4'b1010;
      run_sprite(1, 1'b0, 4'b1010, 1'b0, tmp);
      run_sprite(3, 1'b0, 4'b0000, 1'b0, tmp);
      // Pointer wrapped to 0: requester 0 must beat 1 and 3.
      set_base(0, 60, 50, 3'd1);
      req = 4'b1011;
      run_sprite(0, 1'b0, 4'b0000, 1'b0, tmp);

      // Clipping: fully off-screen, exactly on the corner, one column past.
      set_base(2, 155, 115, 3'd3);
      req = 4'b0100;
      run_sprite(2, 1'b1, 4'b0000, 1'b0, tmp);
      set_base(2, 151, 109, 3'd4);
      req = 4'b0100;
      run_sprite(2, 1'b1, 4'b0000, 1'b0, tmp);
      set_base(2, 152, 109, 3'd4);
      req = 4'b0100;
      run_sprite(2, 1'b1, 4'b0000, 1'b0, tmp);

      // Base inputs scrambled after LOAD must not affect the plotted pixels.
      set_base(2, 30, 40, 3'd6);
      req = 4'b0100;
      run_sprite(2, 1'b0, 4'b0000, 1'b1, tmp);

      // Asynchronous reset during the 10th DRAW cycle.
      set_base(0, 10, 20, 3'd5);
      tbl_mode = 1'b0;
      push_sprite(0, 1'b0, tmp);
      req = 4'b0001;
      step();
      chk("r4_grant", {28'd0, grant}, 32'd1);
      req = 4'b0000;
      for (int i = 0; i < 10; i++) step();
      chk("r4_plot_before", {31'd0, plot}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("r4_plot", {31'd0, plot}, 32'd0);
      chk("r4_grant0", {28'd0, grant}, 32'd0);
      chk("r4_busy", {31'd0, busy}, 32'd0);
      chk("r4_pix", {27'd0, pix_idx}, 32'd0);
      sb.delete();
      for (int i = 0; i < 3; i++) begin
         step();
         chk("r4_nodone", {28'd0, done}, 32'd0);
      end
      reset = 1'b0;
      step();
      chk("r4_nodone_after", {28'd0, done}, 32'd0);
      req = 4'b0001;
      run_sprite(0, 1'b0, 4'b0000, 1'b0, tmp);

      // All four held: strict rotation 0,1,2,3,0 at a 26-cycle period.
      reset_pulse();
      set_base(0, 0, 0, 3'd1);
      set_base(1, 50, 30, 3'd2);
      set_base(2, 145, 97, 3'd3);
      set_base(3, 140, 100, 3'd4);
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         run_sprite(i % 4, 1'b0, (i == 4) ? 4'b0000 : 4'b1111, 1'b0, lc[i]);
      end
      for (int i = 1; i < 5; i++) chk("rr_period", lc[i] - lc[i-1], PIXELS + 3);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
